// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared sizes, operand type and feeder FSM states for the systolic array
package systolic_pkg;

  localparam int systolic_size_c = 4;
  localparam int data_w_c        = 8;

  typedef logic [data_w_c-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DONE
  } feed_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage {valid,data} shift register with sync active-low clear
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [DEPTH-1:0]             valid_sr;
  logic [DEPTH-1:0][DATA_W-1:0] data_sr;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      valid_sr <= '0;
      data_sr  <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      data_sr[0]  <= in_data;
      for (int s = 1; s < DEPTH; s++) begin
        valid_sr[s] <= valid_sr[s-1];
        data_sr[s]  <= data_sr[s-1];
      end
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_data  = data_sr[DEPTH-1];

endmodule

// File: rtl/operand_skew_feeder.sv
// rtl/operand_skew_feeder.sv - west-edge operand feeder applying triangular skew into the MAC array rows
module operand_skew_feeder
  import systolic_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = systolic_size_c,
  parameter int DATA_W        = data_w_c,
  parameter int LEN_W         = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [LEN_W-1:0]                k_len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SYSTOLIC_SIZE*DATA_W-1:0] in_data,
  output logic [SYSTOLIC_SIZE*DATA_W-1:0] arr_data,
  output logic [SYSTOLIC_SIZE-1:0]        arr_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int FLUSH_W = $clog2(SYSTOLIC_SIZE);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYSTOLIC_SIZE - 1);

  feed_state_e        state;
  logic [LEN_W-1:0]   k_len_q;
  logic [LEN_W-1:0]   acc_cnt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               accept;

  assign in_ready = (state == FEED);
  assign accept   = in_valid && in_ready;

  // FLUSH lasts until the last vector has left lane N-1, so done follows the final lane output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_len_q   <= '0;
      acc_cnt   <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_len_q <= k_len;
            acc_cnt <= '0;
            if (k_len != '0) begin
              state <= FEED;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        FEED: begin
          if (accept) begin
            acc_cnt <= acc_cnt + LEN_W'(1);
            if (acc_cnt == k_len_q - LEN_W'(1)) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Non-handshake cycles inject zero bubbles so idle lanes always read as data 0.
  for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_lane
    logic [DATA_W-1:0] lane_in;

    assign lane_in = accept ? in_data[i*DATA_W +: DATA_W] : '0;

    skew_delay_line #(
      .DEPTH  (i + 1),
      .DATA_W (DATA_W)
    ) u_delay (
      .clk       (clk),
      .clr_n     (rst_n),
      .in_valid  (accept),
      .in_data   (lane_in),
      .out_valid (arr_valid[i]),
      .out_data  (arr_data[i*DATA_W +: DATA_W])
    );
  end

endmodule
